// File: rtl/tidc_params.sv
// Shared TIDC constants: L2 command encodings and cache-line geometry.
// Combinational definitions only; no latency, no flow control.
package tidc_params;

    localparam logic [2:0] L2_CMD_READ       = 3'd0;
    localparam logic [2:0] L2_CMD_WRITE      = 3'd1;
    localparam logic [2:0] L2_CMD_WRITE_BACK = 3'd2;

    localparam int L2_LINE_BYTES     = 64;
    localparam int L2_LINE_SIZE_LOG2 = 6;

    function automatic logic l2_cmd_legal(input logic [2:0] typ);
        return (typ == L2_CMD_READ) || (typ == L2_CMD_WRITE) || (typ == L2_CMD_WRITE_BACK);
    endfunction

endpackage

// File: rtl/tidc_l2_mem_ctrl_if.sv
// Command strobe from tidc_top into the L2 and the registered response pulse back.
// No ready: the L2 drops commands it cannot buffer and reports it out of band.
interface tidc_l2_mem_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic              l2_cmd_valid;
    logic [2:0]        l2_cmd_type;
    logic [ADDR_W-1:0] l2_cmd_addr;
    logic [DATA_W-1:0] l2_cmd_data;
    logic [3:0]        l2_cmd_size;
    logic              l2_cmd_dirty;
    logic              l2_response_valid;
    logic [DATA_W-1:0] l2_response_data;
    logic              l2_response_error;

    modport master (
        output l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_data, l2_cmd_size, l2_cmd_dirty,
        input  l2_response_valid, l2_response_data, l2_response_error
    );

    modport slave (
        input  l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_data, l2_cmd_size, l2_cmd_dirty,
        output l2_response_valid, l2_response_data, l2_response_error
    );
endinterface

// File: rtl/tidc_sync_fifo.sv
// Generic synchronous FIFO with fall-through head; pop data valid whenever !empty.
// A push while full is accepted only when a pop happens in the same cycle.
module tidc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/tidc_l2_mem_ctrl.sv
// L2 memory controller: FIFO-buffered commands served one at a time, response MEM_LAT+1 cycles after an idle command.
// No backpressure; commands arriving with the FIFO full (and no pop) are dropped and flagged sticky in cmd_overflow.
import tidc_params::*;

module tidc_l2_mem_ctrl #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int MEM_LINES = 1024,
    parameter int MEM_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tidc_l2_mem_ctrl_if.slave    l2,
    output logic                 busy,
    output logic                 cmd_overflow
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    typedef struct packed {
        logic [2:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        size;
        logic              dirty;
    } entry_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    entry_t            svc;
    entry_t            push_ent;
    entry_t            pop_ent;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [IDX_W-1:0]  svc_idx;
    logic              svc_err;
    logic              exec;
    logic              mem_we;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_error;
    logic [DATA_W-1:0] mem [MEM_LINES];

    always_comb begin
        push_ent       = '0;
        push_ent.typ   = l2.l2_cmd_type;
        push_ent.addr  = l2.l2_cmd_addr;
        push_ent.data  = l2.l2_cmd_data;
        push_ent.size  = l2.l2_cmd_size;
        push_ent.dirty = l2.l2_cmd_dirty;
    end

    tidc_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (l2.l2_cmd_valid),
        .push_dat (push_ent),
        .pop      (pop),
        .pop_dat  (pop_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop  = (state == IDLE) && !fifo_empty;
    assign busy = !fifo_empty || (state != IDLE);

    // Lines above MEM_LINES are rejected rather than aliased onto low lines.
    assign svc_idx = svc.addr[L2_LINE_SIZE_LOG2 +: IDX_W];
    assign svc_err = (svc.addr[L2_LINE_SIZE_LOG2-1:0] != '0)
                  || ((svc.addr >> (L2_LINE_SIZE_LOG2 + IDX_W)) != '0)
                  || (svc.size != 4'(L2_LINE_SIZE_LOG2))
                  || !l2_cmd_legal(svc.typ);
    assign exec    = (state == SERVE) && (cnt == '0);
    assign mem_we  = exec && !svc_err
                  && ((svc.typ == L2_CMD_WRITE) || ((svc.typ == L2_CMD_WRITE_BACK) && svc.dirty));

    // Backing store survives reset so lines written before it stay readable.
    always_ff @(posedge clk) begin
        if (mem_we) mem[svc_idx] <= svc.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            svc          <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_error   <= 1'b0;
            cmd_overflow <= 1'b0;
        end else begin
            if (l2.l2_cmd_valid && fifo_full && !pop) cmd_overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        svc   <= pop_ent;
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= svc_err;
                        if (svc_err)                    resp_data <= '0;
                        else if (svc.typ == L2_CMD_READ) resp_data <= mem[svc_idx];
                        else                            resp_data <= svc.data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign l2.l2_response_valid = resp_valid;
    assign l2.l2_response_data  = resp_data;
    assign l2.l2_response_error = resp_error;
endmodule

// File: tb/tb_tidc_l2_mem_ctrl.sv
// Directed and randomized bench for tidc_l2_mem_ctrl against an in-order line-memory reference model.
import tidc_params::*;

module tb_tidc_l2_mem_ctrl;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int MEM_LINES = 1024;
    localparam int MEM_LAT   = 4;

    typedef logic [DATA_W-1:0] line_t;
    typedef struct {
        line_t data;
        logic  err;
        bit    chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic cmd_overflow;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    int          resp_cnt = 0;
    int          last_cmd_cyc;
    exp_t        exp_q[$];
    int          resp_cyc_q[$];
    line_t       mem_m[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tidc_l2_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) l2 ();

    tidc_l2_mem_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LINES (MEM_LINES),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l2           (l2),
        .busy         (busy),
        .cmd_overflow (cmd_overflow)
    );

    task automatic chk(input string tag, input line_t obs, input line_t expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: every accepted command resolves in arrival order against a flat line array.
    task automatic model(input logic [2:0] t, input logic [ADDR_W-1:0] a, input line_t d,
                         input logic [3:0] s, input logic dirty);
        exp_t e;
        bit   bad;
        int   idx;
        bad = (a % 64 != 0) || (a >= 64'(64 * MEM_LINES)) || (s != 4'd6)
           || !((t == L2_CMD_READ) || (t == L2_CMD_WRITE) || (t == L2_CMD_WRITE_BACK));
        idx = int'(a / 64);
        e.err = 1'b0;
        e.data = d;
        e.chk_data = 1'b1;
        if (bad) begin
            e.err  = 1'b1;
            e.data = '0;
        end else if (t == L2_CMD_READ) begin
            if (mem_m.exists(idx)) e.data = mem_m[idx];
            else                   e.chk_data = 1'b0;
        end else if (t == L2_CMD_WRITE || dirty) begin
            mem_m[idx] = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] t, input logic [ADDR_W-1:0] a, input line_t d,
                        input logic [3:0] s, input logic dirty, input bit accept);
        l2.l2_cmd_valid = 1'b1;
        l2.l2_cmd_type  = t;
        l2.l2_cmd_addr  = a;
        l2.l2_cmd_data  = d;
        l2.l2_cmd_size  = s;
        l2.l2_cmd_dirty = dirty;
        @(posedge clk);
        #1;
        l2.l2_cmd_valid = 1'b0;
        last_cmd_cyc = cyc;
        if (accept) model(t, a, d, s, dirty);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        chk(tag, line_t'(done), 1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_resp_valid"}, line_t'(l2.l2_response_valid), 0);
        chk({pfx, "_resp_data"},  l2.l2_response_data, 0);
        chk({pfx, "_resp_error"}, line_t'(l2.l2_response_error), 0);
        chk({pfx, "_busy"},       line_t'(busy), 0);
        chk({pfx, "_overflow"},   line_t'(cmd_overflow), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && l2.l2_response_valid === 1'b1) begin
            resp_cnt++;
            resp_cyc_q.push_back(cyc);
            chk("resp_expected", line_t'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_error", line_t'(l2.l2_response_error), line_t'(e.err));
                if (e.chk_data) chk("resp_data", l2.l2_response_data, e.data);
            end
        end
    end

    initial begin
        line_t a_dat, b_dat, c_dat, d_dat, p_dat;
        int t0, base, sel, n;
        logic [2:0] t;
        logic [ADDR_W-1:0] a;
        logic [3:0] s;

        l2.l2_cmd_valid = 1'b0;
        l2.l2_cmd_type  = '0;
        l2.l2_cmd_addr  = '0;
        l2.l2_cmd_data  = '0;
        l2.l2_cmd_size  = '0;
        l2.l2_cmd_dirty = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read the same line; check latency and service spacing.
        a_dat = rand_line();
        resp_cyc_q.delete();
        send(L2_CMD_WRITE, 64'h1000, a_dat, 4'd6, 1'b0, 1'b1);
        t0 = last_cmd_cyc;
        send(L2_CMD_READ, 64'h1000, '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_wr_rd");
        chk("resp_count_wr_rd", line_t'(resp_cyc_q.size()), 2);
        if (resp_cyc_q.size() >= 2) begin
            chk("first_latency", line_t'(resp_cyc_q[0] - t0), MEM_LAT + 1);
            chk("resp_spacing", line_t'(resp_cyc_q[1] - resp_cyc_q[0]), MEM_LAT + 2);
        end
        chk("data_hold", l2.l2_response_data, a_dat);

        // Malformed commands, then confirm line 0x1000 untouched.
        send(L2_CMD_READ, 64'h1004, '0, 4'd6, 1'b0, 1'b1);
        send(L2_CMD_READ, 64'h1000, '0, 4'd5, 1'b0, 1'b1);
        send(3'd7, 64'h1000, rand_line(), 4'd6, 1'b0, 1'b1);
        wait_idle("idle_err1");
        chk("err_hold_error", line_t'(l2.l2_response_error), 1);
        chk("err_hold_data", l2.l2_response_data, 0);
        send(L2_CMD_READ, 64'h1_0000, '0, 4'd6, 1'b0, 1'b1);
        send(L2_CMD_WRITE, 64'h1000, rand_line(), 4'd5, 1'b0, 1'b1);
        send(L2_CMD_READ, 64'h1000, '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_err2");

        // Write-back clean leaves memory, dirty updates it.
        b_dat = rand_line();
        c_dat = rand_line();
        send(L2_CMD_WRITE, 64'h2000, b_dat, 4'd6, 1'b0, 1'b1);
        send(L2_CMD_WRITE_BACK, 64'h2000, rand_line(), 4'd6, 1'b0, 1'b1);
        send(L2_CMD_READ, 64'h2000, '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_wb_clean");
        send(L2_CMD_WRITE_BACK, 64'h2000, c_dat, 4'd6, 1'b1, 1'b1);
        send(L2_CMD_READ, 64'h2000, '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_wb_dirty");

        // Random bursts of up to three commands over a few colliding lines.
        for (int b = 0; b < 25; b++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 3)      t = L2_CMD_READ;
                else if (sel <= 6) t = L2_CMD_WRITE;
                else if (sel <= 8) t = L2_CMD_WRITE_BACK;
                else               t = 3'($urandom_range(3, 7));
                a = 64'h8000 + 64'($urandom_range(0, 7)) * 64;
                if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 63));
                s = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 5)) : 4'd6;
                send(t, a, rand_line(), s, 1'($urandom_range(0, 1)), 1'b1);
            end
            wait_idle("idle_rand");
        end
        chk("no_overflow_yet", line_t'(cmd_overflow), 0);

        // DEPTH+2 back-to-back strobes: last one is dropped.
        p_dat = rand_line();
        send(L2_CMD_WRITE, 64'h4000 + 64'((DEPTH + 1) * 64), p_dat, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_pre_ovf");
        base = resp_cnt;
        for (int i = 0; i < DEPTH + 2; i++)
            send(L2_CMD_WRITE, 64'h4000 + 64'(i * 64), rand_line(), 4'd6, 1'b0, i < DEPTH + 1);
        wait_idle("idle_ovf");
        chk("ovf_resp_count", line_t'(resp_cnt - base), DEPTH + 1);
        chk("ovf_sticky", line_t'(cmd_overflow), 1);
        chk("ovf_busy_low", line_t'(busy), 0);
        send(L2_CMD_READ, 64'h4000 + 64'((DEPTH + 1) * 64), '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_ovf_rd");

        // Reset during SERVE with two queued commands.
        d_dat = rand_line();
        send(L2_CMD_WRITE, 64'h3000, d_dat, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_pre_rst");
        for (int i = 0; i < 3; i++) send(L2_CMD_READ, 64'h3000, '0, 4'd6, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        base = resp_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no_resp_after_rst", line_t'(resp_cnt - base), 0);
        chk("busy_after_rst", line_t'(busy), 0);
        send(L2_CMD_READ, 64'h3000, '0, 4'd6, 1'b0, 1'b1);
        send(L2_CMD_READ, 64'h1000, '0, 4'd6, 1'b0, 1'b1);
        wait_idle("idle_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
